mig_ui_responder: RTL and testbench
===================================

Name: mig_ui_responder

Overview:
- Synthesizable MIG user-interface responder: the memory-side end of the MIG UI protocol that the traffic generator drives.
- Stands in for the DDR3 MIG in simulation and in loopback bring-up builds.
- Backs a BRAM array of 128-bit words and returns read data in order after a fixed latency.
- Models calibration delay, app_rdy/app_wdf_rdy back-pressure and maintenance-request acks, so that initiators can be exercised without the DDR3 controller.

Parameters:
- DEPTH_WORDS, 1024: number of 128-bit words; power of 2.
- RD_LATENCY, 8: cycles from read-command acceptance to app_rd_data_valid; legal range 2..32.
- CALIB_CYCLES, 16: cycles after reset before init_calib_complete rises.
- MAX_RD_OUTSTANDING, 16: accepted reads not yet returned; app_rdy drops at this limit.
- STALL_PERIOD, 0: if nonzero, app_rdy is forced low one cycle in every STALL_PERIOD; 0 disables stalls.
- WDF_DEPTH, 4: write-data FIFO entries.

Ports:
- clk_in  input  1  UI clock
- rst_in  input  1  synchronous active-high reset
- app_addr  input  27  byte address; word index = app_addr[26:3] mod DEPTH_WORDS; bits [2:0] ignored
- app_cmd  input  3  000 write, 001 read
- app_en  input  1  command valid
- app_wdf_data  input  128  write data
- app_wdf_end  input  1  last beat of write data (always 1, single-beat)
- app_wdf_wren  input  1  write data valid
- app_wdf_mask  input  16  byte mask; 1 = byte not written
- app_rd_data  output  128  read data
- app_rd_data_end  output  1  equals app_rd_data_valid
- app_rd_data_valid  output  1  read data valid
- app_rdy  output  1  command accepted this cycle if app_en
- app_wdf_rdy  output  1  write data accepted this cycle if app_wdf_wren
- app_sr_req  input  1  self-refresh request
- app_ref_req  input  1  refresh request
- app_zq_req  input  1  ZQ calibration request
- app_sr_active  output  1  tied 0
- app_ref_ack  output  1  refresh acknowledge pulse
- app_zq_ack  output  1  ZQ acknowledge pulse
- init_calib_complete  output  1  calibration done
- protocol_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_in high at a clock edge) clears the following:
  - All outputs are 0.
  - The calibration counter is 0.
  - The read pipeline and write-data FIFO are emptied; in-flight reads are discarded and never returned.
  - protocol_err is 0.
  - Memory contents are NOT cleared.
- Calibration:
  - The counter increments each cycle after reset.
  - init_calib_complete rises on the CALIB_CYCLES-th cycle after rst_in falls and stays high until the next reset.
  - app_rdy and app_wdf_rdy are 0 while init_calib_complete is 0.
- app_rdy is combinational from registered state. It is high when all of the following hold:
  - calibration is complete;
  - outstanding reads < MAX_RD_OUTSTANDING;
  - no stall cycle is active. The stall counter is free-running, wraps at STALL_PERIOD-1, and the stall cycle is count==STALL_PERIOD-1.
- app_wdf_rdy = calibration complete AND write-data FIFO not full.
- Write data is pushed into the FIFO on app_wdf_wren && app_wdf_rdy.
- Write command (app_en && app_rdy && app_cmd==000):
  - Pops one FIFO entry. Same-cycle data bypasses the FIFO when the FIFO is empty.
  - Each byte i with mask[i]==0 is written to the addressed word at that clock edge.
  - If neither a FIFO entry nor same-cycle data exists, the command is dropped and protocol_err is set.
- Read command (app_en && app_rdy && app_cmd==001):
  - Memory is read at acceptance.
  - The word is returned with app_rd_data_valid=app_rd_data_end=1 exactly RD_LATENCY cycles later.
  - Returns are strictly in order.
  - The read reflects all writes committed on earlier edges.
- Outstanding-read count:
  - +1 on read acceptance, −1 on return.
  - Simultaneous accept and return leave it unchanged.
- Any other app_cmd value accepted (app_en && app_rdy) is ignored and sets protocol_err.
- Maintenance requests:
  - app_ref_req and app_zq_req each produce a 1-cycle ack pulse on the cycle after the request's rising edge.
  - app_sr_req is ignored.
- protocol_err clears only on reset.

Test Plan:
- Reset, then hold app_en=1 with a read → init_calib_complete=0 and app_rdy=0 for cycles 0..15; app_rdy=1 from cycle 16; read accepted at cycle 16.
- Write addr 0x000008, data 0x0123…CDEF, mask 0, same-cycle command and data; read addr 0x000008 next cycle → data returned exactly 8 cycles after the read is accepted, valid=end=1 for one cycle.
- Write addr 0x10 with data all 0xFF, then write addr 0x10 with data all 0x00 and mask 0x000F; read → bytes 0–3 = 0xFF, bytes 4–15 = 0x00.
- Issue 20 back-to-back reads to addresses 0..19 (word index) with RD_LATENCY=8 and MAX_RD_OUTSTANDING=16 → app_rdy low after 16 outstanding; 20 returns in address order with no gaps lost.
- STALL_PERIOD=4 with a continuous write stream → app_rdy low on exactly 1 of every 4 cycles; all writes land.
- Write command with no data → protocol_err=1 and memory unchanged. Reset mid-read-burst → no app_rd_data_valid after reset; memory retains the prior write.

Source files
------------

// File: rtl/mig_ui_responder.sv
// MIG user-interface responder: BRAM-backed stand-in for the DDR3 MIG with calibration delay,
// fixed-latency in-order read returns, a small write-data FIFO and maintenance-request acks.
module mig_ui_responder #(
  parameter int DEPTH_WORDS        = 1024,
  parameter int RD_LATENCY         = 8,
  parameter int CALIB_CYCLES       = 16,
  parameter int MAX_RD_OUTSTANDING = 16,
  parameter int STALL_PERIOD       = 0,
  parameter int WDF_DEPTH          = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [26:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  input  logic [127:0] app_wdf_data,
  input  logic         app_wdf_end,
  input  logic         app_wdf_wren,
  input  logic [15:0]  app_wdf_mask,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_end,
  output logic         app_rd_data_valid,
  output logic         app_rdy,
  output logic         app_wdf_rdy,
  input  logic         app_sr_req,
  input  logic         app_ref_req,
  input  logic         app_zq_req,
  output logic         app_sr_active,
  output logic         app_ref_ack,
  output logic         app_zq_ack,
  output logic         init_calib_complete,
  output logic         protocol_err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int OW  = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam int RPW = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
  localparam int WPW = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int WCW = $clog2(WDF_DEPTH + 1);
  localparam int CW  = $clog2(CALIB_CYCLES + 1);
  localparam int SW  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int PL  = RD_LATENCY - 1;

  localparam logic [OW-1:0]  OUT_MAX  = OW'(MAX_RD_OUTSTANDING);
  localparam logic [WCW-1:0] WDF_FULL = WCW'(WDF_DEPTH);
  localparam logic [CW-1:0]  CAL_LAST = CW'(CALIB_CYCLES - 1);
  localparam logic [RPW-1:0] RQ_LAST  = RPW'(MAX_RD_OUTSTANDING - 1);
  localparam logic [WPW-1:0] WQ_LAST  = WPW'(WDF_DEPTH - 1);

  function automatic logic [RPW-1:0] rq_next(input logic [RPW-1:0] p);
    if (p == RQ_LAST) return {RPW{1'b0}};
    else return p + RPW'(1);
  endfunction

  function automatic logic [WPW-1:0] wq_next(input logic [WPW-1:0] p);
    if (p == WQ_LAST) return {WPW{1'b0}};
    else return p + WPW'(1);
  endfunction

  function automatic logic [127:0] merge_bytes(input logic [127:0] old_w,
                                               input logic [127:0] new_w,
                                               input logic [15:0]  mask);
    logic [127:0] res;
    res = old_w;
    for (int b = 0; b < 16; b++) begin
      if (!mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
      else          res[8*b +: 8] = old_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [127:0]   mem_r      [DEPTH_WORDS];
  logic [127:0]   rdq_r      [MAX_RD_OUTSTANDING];
  logic [127:0]   wdq_data_r [WDF_DEPTH];
  logic [15:0]    wdq_mask_r [WDF_DEPTH];
  logic [RPW-1:0] rq_wp_r, rq_rp_r;
  logic [WPW-1:0] wq_wp_r, wq_rp_r;
  logic [WCW-1:0] wq_cnt_r;
  logic [CW-1:0]  cal_cnt_r;
  logic           cal_done_r;
  logic [OW-1:0]  out_cnt_r;
  logic [PL-1:0]  pipe_r;
  logic [127:0]   rd_data_r;
  logic           rd_valid_r, perr_r, ref_d_r, zq_d_r, ref_ack_r, zq_ack_r;

  logic [AW-1:0]  idx_s;
  logic           acc_s, wr_cmd_s, rd_cmd_s, bad_cmd_s, wdf_push_s, wq_empty_s;
  logic           wr_commit_s, wr_drop_s, wq_pop_s, wq_store_s, stall_s, rdy_s, wrdy_s;
  logic [127:0]   wr_data_s;
  logic [15:0]    wr_mask_s;
  logic           unused_s;

  assign unused_s = ^{app_wdf_end, app_sr_req, app_addr};
  assign idx_s    = app_addr[3 +: AW];
  assign rdy_s    = cal_done_r && (out_cnt_r < OUT_MAX) && !stall_s;
  assign wrdy_s   = cal_done_r && (wq_cnt_r != WDF_FULL);

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [SW-1:0] st_cnt_r;
      // Free-running stall phase; the last phase of each period blocks commands
      always_ff @(posedge clk_in) begin
        if (rst_in) st_cnt_r <= SW'(0);
        else if (st_cnt_r == SW'(STALL_PERIOD - 1)) st_cnt_r <= SW'(0);
        else st_cnt_r <= st_cnt_r + SW'(1);
      end
      assign stall_s = (st_cnt_r == SW'(STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign stall_s = 1'b0;
    end
  endgenerate

  // Command decode and write-data source selection (FIFO head, else same-cycle bypass)
  always_comb begin
    acc_s      = app_en && rdy_s;
    wr_cmd_s   = 1'b0;
    rd_cmd_s   = 1'b0;
    bad_cmd_s  = 1'b0;
    case (app_cmd)
      3'b000:  wr_cmd_s  = acc_s;
      3'b001:  rd_cmd_s  = acc_s;
      default: bad_cmd_s = acc_s;
    endcase
    wdf_push_s  = app_wdf_wren && wrdy_s;
    wq_empty_s  = (wq_cnt_r == WCW'(0));
    wr_commit_s = wr_cmd_s && (!wq_empty_s || wdf_push_s);
    wr_drop_s   = wr_cmd_s && wq_empty_s && !wdf_push_s;
    if (wq_empty_s) begin
      wr_data_s  = app_wdf_data;
      wr_mask_s  = app_wdf_mask;
      wq_pop_s   = 1'b0;
      wq_store_s = wdf_push_s && !wr_cmd_s;
    end else begin
      wr_data_s  = wdq_data_r[wq_rp_r];
      wr_mask_s  = wdq_mask_r[wq_rp_r];
      wq_pop_s   = wr_cmd_s;
      wq_store_s = wdf_push_s;
    end
  end

  // Control state: calibration, read return pipeline, queue pointers, flags and acks
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cal_cnt_r  <= CW'(0);
      cal_done_r <= 1'b0;
      out_cnt_r  <= OW'(0);
      pipe_r     <= PL'(0);
      rd_data_r  <= 128'h0;
      rd_valid_r <= 1'b0;
      rq_wp_r    <= RPW'(0);
      rq_rp_r    <= RPW'(0);
      wq_wp_r    <= WPW'(0);
      wq_rp_r    <= WPW'(0);
      wq_cnt_r   <= WCW'(0);
      perr_r     <= 1'b0;
      ref_d_r    <= 1'b0;
      zq_d_r     <= 1'b0;
      ref_ack_r  <= 1'b0;
      zq_ack_r   <= 1'b0;
    end else begin
      if (!cal_done_r) begin
        cal_cnt_r  <= cal_cnt_r + CW'(1);
        cal_done_r <= (cal_cnt_r == CAL_LAST);
      end
      pipe_r[0] <= rd_cmd_s;
      for (int i = 1; i < PL; i++) pipe_r[i] <= pipe_r[i-1];
      rd_valid_r <= pipe_r[PL-1];
      if (pipe_r[PL-1]) begin
        rd_data_r <= rdq_r[rq_rp_r];
        rq_rp_r   <= rq_next(rq_rp_r);
      end
      if (rd_cmd_s) rq_wp_r <= rq_next(rq_wp_r);
      case ({rd_cmd_s, rd_valid_r})
        2'b10:   out_cnt_r <= out_cnt_r + OW'(1);
        2'b01:   out_cnt_r <= out_cnt_r - OW'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase
      if (wq_store_s) wq_wp_r <= wq_next(wq_wp_r);
      if (wq_pop_s)   wq_rp_r <= wq_next(wq_rp_r);
      case ({wq_store_s, wq_pop_s})
        2'b10:   wq_cnt_r <= wq_cnt_r + WCW'(1);
        2'b01:   wq_cnt_r <= wq_cnt_r - WCW'(1);
        default: wq_cnt_r <= wq_cnt_r;
      endcase
      if (wr_drop_s || bad_cmd_s) perr_r <= 1'b1;
      ref_d_r   <= app_ref_req;
      zq_d_r    <= app_zq_req;
      ref_ack_r <= app_ref_req && !ref_d_r;
      zq_ack_r  <= app_zq_req && !zq_d_r;
    end
  end

  // Storage arrays; memory survives reset, reads snapshot the word at acceptance
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (wr_commit_s) mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wr_data_s, wr_mask_s);
      if (rd_cmd_s)    rdq_r[rq_wp_r] <= mem_r[idx_s];
      if (wq_store_s) begin
        wdq_data_r[wq_wp_r] <= app_wdf_data;
        wdq_mask_r[wq_wp_r] <= app_wdf_mask;
      end
    end
  end

  assign app_rd_data         = rd_data_r;
  assign app_rd_data_valid   = rd_valid_r;
  assign app_rd_data_end     = rd_valid_r;
  assign app_rdy             = rdy_s;
  assign app_wdf_rdy         = wrdy_s;
  assign app_sr_active       = 1'b0;
  assign app_ref_ack         = ref_ack_r;
  assign app_zq_ack          = zq_ack_r;
  assign init_calib_complete = cal_done_r;
  assign protocol_err        = perr_r;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed/randomized bench for mig_ui_responder against a queue-based reference model.
module tb_mig_ui_responder;
  localparam int DW = 64, LAT = 8, CAL = 16, MAXO = 6, STP = 4, WDQ = 4;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_in = 1'b1;
  logic [26:0]  app_addr = 27'h0;
  logic [2:0]   app_cmd = 3'b000;
  logic         app_en = 1'b0;
  logic [127:0] app_wdf_data = 128'h0;
  logic         app_wdf_end = 1'b1;
  logic         app_wdf_wren = 1'b0;
  logic [15:0]  app_wdf_mask = 16'h0;
  logic         app_sr_req = 1'b0, app_ref_req = 1'b0, app_zq_req = 1'b0;
  logic [127:0] app_rd_data;
  logic         app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy;
  logic         app_sr_active, app_ref_ack, app_zq_ack, init_calib_complete, protocol_err;

  mig_ui_responder #(.DEPTH_WORDS(DW), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL),
                     .MAX_RD_OUTSTANDING(MAXO), .STALL_PERIOD(STP), .WDF_DEPTH(WDQ)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_wren(app_wdf_wren),
    .app_wdf_mask(app_wdf_mask), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
    .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
    .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
    .init_calib_complete(init_calib_complete), .protocol_err(protocol_err));

  typedef struct { int due; logic [127:0] data; } rd_t;
  typedef struct { logic [127:0] data; logic [15:0] mask; } wd_t;
  rd_t          rq[$];
  wd_t          wq[$];
  logic [127:0] ref_mem [DW];
  int  cyc = 0, checks = 0, errors = 0, acc_cycle = 0, ret_cnt = 0, rdy_low_cnt = 0;
  bit  exp_perr = 0, exp_ref_ack = 0, exp_zq_ack = 0, ref_prev = 0, zq_prev = 0;
  bit  cmd_taken = 0, data_taken = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
    for (int b = 0; b < 16; b++)
      if (!m[b]) ref_mem[int'(a[8:3])][8*b +: 8] = d[8*b +: 8];
  endtask

  // One clock cycle: compare outputs with the model, advance the model, step the clock.
  task automatic tick();
    bit  e_rdy, e_wrdy, e_val, push;
    rd_t r;
    wd_t w;
    e_rdy  = (cyc >= CAL) && (rq.size() < MAXO) && ((cyc % STP) != STP - 1);
    e_wrdy = (cyc >= CAL) && (wq.size() < WDQ);
    e_val  = (rq.size() > 0) && (rq[0].due == cyc);
    chk("app_rdy", app_rdy, e_rdy);
    chk("app_wdf_rdy", app_wdf_rdy, e_wrdy);
    chk("init_calib", init_calib_complete, cyc >= CAL);
    chk("rd_valid", app_rd_data_valid, e_val);
    chk("rd_end", app_rd_data_end, e_val);
    chk("protocol_err", protocol_err, exp_perr);
    chk("ref_ack", app_ref_ack, exp_ref_ack);
    chk("zq_ack", app_zq_ack, exp_zq_ack);
    chk("sr_active", app_sr_active, 1'b0);
    if (e_val) begin
      chk("rd_data", app_rd_data, rq[0].data);
      void'(rq.pop_front());
    end
    if (app_rd_data_valid) ret_cnt++;
    if (!app_rdy) rdy_low_cnt++;
    cmd_taken = 0;
    data_taken = 0;
    push = app_wdf_wren && e_wrdy;
    if (app_en && e_rdy) begin
      cmd_taken = 1;
      acc_cycle = cyc;
      case (app_cmd)
        3'b000: begin
          if (wq.size() > 0) begin
            w = wq.pop_front();
            model_write(app_addr, w.data, w.mask);
          end else if (push) begin
            model_write(app_addr, app_wdf_data, app_wdf_mask);
            push = 0;
            data_taken = 1;
          end else exp_perr = 1;
        end
        3'b001: begin
          r.due = cyc + LAT;
          r.data = ref_mem[int'(app_addr[8:3])];
          rq.push_back(r);
        end
        default: exp_perr = 1;
      endcase
    end
    if (push) begin
      w.data = app_wdf_data;
      w.mask = app_wdf_mask;
      wq.push_back(w);
      data_taken = 1;
    end
    exp_ref_ack = app_ref_req && !ref_prev;
    ref_prev = app_ref_req;
    exp_zq_ack = app_zq_req && !zq_prev;
    zq_prev = app_zq_req;
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; app_en = 1'b0; app_wdf_wren = 1'b0; app_ref_req = 1'b0; app_zq_req = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    rq.delete(); wq.delete();
    exp_perr = 0; exp_ref_ack = 0; exp_zq_ack = 0; ref_prev = 0; zq_prev = 0; cyc = 0;
    chk("rst_rd_data", app_rd_data, 128'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      app_ref_req = 1'($urandom_range(0, 1));
      app_zq_req  = 1'($urandom_range(0, 1));
      app_sr_req  = 1'($urandom_range(0, 1));
      tick();
    end
    app_ref_req = 1'b0; app_zq_req = 1'b0; app_sr_req = 1'b0;
  endtask

  task automatic wr(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m, input bit with_data);
    int n;
    bit cdone, ddone;
    n = 0; cdone = 0; ddone = !with_data;
    app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
    app_wdf_wren = with_data; app_wdf_data = d; app_wdf_mask = m;
    while (!(cdone && ddone) && n < 64) begin
      tick();
      if (cmd_taken) begin cdone = 1; app_en = 1'b0; end
      if (data_taken) begin ddone = 1; app_wdf_wren = 1'b0; end
      n++;
    end
    app_en = 1'b0; app_wdf_wren = 1'b0;
    chk("wr_bound", n < 64, 1'b1);
  endtask

  task automatic push_data(input logic [127:0] d, input logic [15:0] m);
    int n;
    n = 0;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    do begin tick(); n++; end while (!data_taken && n < 64);
    app_wdf_wren = 1'b0;
    chk("push_bound", n < 64, 1'b1);
  endtask

  task automatic rd(input logic [26:0] a);
    int n;
    n = 0;
    app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
    do begin tick(); n++; end while (!cmd_taken && n < 64);
    app_en = 1'b0;
    chk("rd_bound", n < 64, 1'b1);
  endtask

  task automatic wait_valid(output int at);
    int n;
    n = 0;
    while (!app_rd_data_valid && n < 20) begin tick(); n++; end
    at = cyc;
    chk("valid_seen", app_rd_data_valid, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rq.size() > 0 && n < 64) begin tick(); n++; end
    chk("drain_bound", n < 64, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rdy, at, acc, c0, low0, exp_low;
    logic [26:0] a;
    for (int i = 0; i < DW; i++) ref_mem[i] = 128'h0;
    do_reset();
    idle(20);
    for (int i = 0; i < DW; i++)
      wr(27'(i << 3), {$urandom, $urandom, $urandom, $urandom}, 16'h0, 1'b1);

    // calibration: read held from cycle 0, first accepted at cycle CAL
    do_reset();
    first_rdy = -1;
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 27'h18;
    while (cyc < 40) begin
      if (app_rdy && first_rdy < 0) first_rdy = cyc;
      tick();
      if (cmd_taken) break;
    end
    app_en = 1'b0;
    chk("first_rdy_cycle", first_rdy, CAL);
    drain();

    // bypass write then read: fixed latency, single-cycle valid
    wr(27'h000008, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h0, 1'b1);
    rd(27'h000008);
    acc = acc_cycle;
    wait_valid(at);
    chk("rd_latency", at - acc, LAT);
    chk("rd_word8", app_rd_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    tick();
    chk("valid_one_cycle", app_rd_data_valid, 1'b0);

    // byte mask merge
    wr(27'h10, {128{1'b1}}, 16'h0, 1'b1);
    wr(27'h10, 128'h0, 16'h000F, 1'b1);
    rd(27'h10);
    wait_valid(at);
    chk("mask_merge", app_rd_data, 128'h000000000000000000000000FFFFFFFF);
    drain();

    // back-to-back reads hit the outstanding limit; all return in order
    ret_cnt = 0;
    for (int i = 0; i < 20; i++) rd(27'(i << 3));
    drain();
    idle(2);
    chk("returns_20", ret_cnt, 20);

    // continuous write stream under periodic stalls
    c0 = cyc; low0 = rdy_low_cnt;
    for (int i = 0; i < 24; i++)
      wr(27'($urandom_range(0, DW - 1) << 3), {$urandom, $urandom, $urandom, $urandom},
         16'($urandom), 1'b1);
    exp_low = 0;
    for (int t = c0; t < cyc; t++) if ((t % STP) == STP - 1) exp_low++;
    chk("stall_low_count", rdy_low_cnt - low0, exp_low);
    for (int i = 0; i < DW; i++) rd(27'(i << 3));
    drain();

    // FIFO-queued data consumed by later data-less commands
    for (int i = 0; i < 3; i++) push_data({$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
    for (int i = 0; i < 3; i++) wr(27'((40 + i) << 3), 128'h0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) rd(27'((40 + i) << 3));
    drain();

    // write command with no data: dropped, flag set, memory unchanged
    chk("perr_clear", protocol_err, 1'b0);
    wr(27'h30 << 3, 128'h0, 16'h0, 1'b0);
    tick();
    chk("perr_set", protocol_err, 1'b1);
    rd(27'h30 << 3);
    drain();

    // reset with reads in flight: nothing returns, memory retained
    a = 27'h2C << 3;
    wr(a, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) rd(27'(i << 3));
    do_reset();
    ret_cnt = 0;
    idle(30);
    chk("no_stale_returns", ret_cnt, 0);
    chk("perr_after_reset", protocol_err, 1'b0);
    rd(a);
    drain();

    // unknown command code
    app_en = 1'b1; app_cmd = 3'b011; app_addr = 27'h0;
    do tick(); while (!cmd_taken && cyc < 200);
    app_en = 1'b0;
    tick();
    chk("bad_cmd_perr", protocol_err, 1'b1);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
